serial_alu_sequencer: RTL



---
 rtl/serial_alu_sequencer_pkg.sv | 28 ++
 rtl/serial_alu_sequencer_slice.sv | 40 ++++
 rtl/serial_alu_sequencer.sv | 107 ++++++++++
 3 files changed

// File: rtl/serial_alu_sequencer_pkg.sv
// Shared definitions for the bit-serial ALU: opcode encodings, FSM state type
// and a small opcode-class helper used by both the sequencer and the 1-bit slice.
package serial_alu_sequencer_pkg;

    localparam int OP_W = 4;

    localparam logic [OP_W-1:0] OP_AND   = 4'd0;
    localparam logic [OP_W-1:0] OP_OR    = 4'd1;
    localparam logic [OP_W-1:0] OP_XOR   = 4'd2;
    localparam logic [OP_W-1:0] OP_NOTA  = 4'd3;
    localparam logic [OP_W-1:0] OP_NOTB  = 4'd4;
    localparam logic [OP_W-1:0] OP_ADD   = 4'd5;
    localparam logic [OP_W-1:0] OP_SUB   = 4'd6;
    localparam logic [OP_W-1:0] OP_PASSA = 4'd7;
    localparam logic [OP_W-1:0] OP_PASSB = 4'd8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Only ADD and SUB propagate a carry between bits.
    function automatic logic is_arith(input logic [OP_W-1:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/serial_alu_sequencer_slice.sv
// Combinational 1-bit ALU slice. SUB is computed as a + ~b + cin, with the
// sequencer seeding cin=1 on the first bit.
module serial_alu_slice
    import serial_alu_sequencer_pkg::*;
(
    input  logic            a,
    input  logic            b,
    input  logic            cin,
    input  logic [OP_W-1:0] sel,
    output logic            r,
    output logic            cout
);

    logic b_eff;

    always_comb begin
        b_eff = (sel == OP_SUB) ? ~b : b;
        r     = 1'b0;
        cout  = 1'b0;
        case (sel)
            OP_AND:   r = a & b;
            OP_OR:    r = a | b;
            OP_XOR:   r = a ^ b;
            OP_NOTA:  r = ~a;
            OP_NOTB:  r = ~b;
            OP_ADD,
            OP_SUB: begin
                r    = a ^ b_eff ^ cin;
                cout = (a & b_eff) | (a & cin) | (b_eff & cin);
            end
            OP_PASSA: r = a;
            OP_PASSB: r = b;
            default: begin
                r    = 1'b0;
                cout = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/serial_alu_sequencer.sv
// Bit-serial ALU sequencer: latches operands, feeds the 1-bit slice LSB-first
// once per clock, and assembles the WIDTH-bit result plus carry/zero flags.
module serial_alu_sequencer
    import serial_alu_sequencer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [OP_W-1:0]  sel,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             zero,
    output state_t           fsm_state
);

    // Handshake: start is a request pulse taken only in a cycle where busy=0;
    // busy stays high from the following cycle through the done cycle, and
    // done is a single-cycle strobe after which result/flags hold until the
    // next accepted start.

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic [WIDTH-1:0] res_sh;
    logic [OP_W-1:0]  op_q;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;

    logic slice_r;
    logic slice_cout;

    serial_alu_slice u_slice (
        .a    (a_sh[0]),
        .b    (b_sh[0]),
        .cin  (carry_q),
        .sel  (op_q),
        .r    (slice_r),
        .cout (slice_cout)
    );

    assign fsm_state = state;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            a_sh      <= '0;
            b_sh      <= '0;
            res_sh    <= '0;
            op_q      <= '0;
            carry_q   <= 1'b0;
            cnt       <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            zero      <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    done <= 1'b0;
                    // busy still high here means this is the done cycle.
                    if (!busy && start) begin
                        a_sh    <= op_a;
                        b_sh    <= op_b;
                        op_q    <= sel;
                        carry_q <= (sel == OP_SUB);
                        cnt     <= '0;
                        busy    <= 1'b1;
                        state   <= ST_RUN;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RUN: begin
                    res_sh  <= {slice_r, res_sh[WIDTH-1:1]};
                    a_sh    <= a_sh >> 1;
                    b_sh    <= b_sh >> 1;
                    carry_q <= slice_cout;
                    cnt     <= cnt + CNT_W'(1);
                    if (cnt == CNT_W'(WIDTH - 1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    done      <= 1'b1;
                    result    <= res_sh;
                    carry_out <= is_arith(op_q) ? carry_q : 1'b0;
                    zero      <= (res_sh == '0);
                    state     <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
